// File: rtl/lut_eval_arbiter_pkg.sv
// Shared types and helpers for the shared, reprogrammable 4-input LUT evaluator.
package lut_eval_arbiter_pkg;

  // Truth-table width and LUT input count
  localparam int LUT_W  = 16;
  localparam int LUT_IN = 4;

  // Serial-load bit counter width and its terminal value
  localparam int                CNT_W    = $clog2(LUT_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LUT_W - 1);

  // Load FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // Evaluate one truth table: the input vector {d,c,b,a} selects the table bit
  function automatic logic lut_lookup(input logic [LUT_W-1:0] tbl,
                                      input logic [LUT_IN-1:0] idx);
    return tbl[idx];
  endfunction

endpackage

// File: rtl/lut_eval_arbiter_if.sv
// Request/response bus between the LUT evaluator and its client blocks.
interface lut_eval_arbiter_if
  import lut_eval_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int SELW = 2
);

  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*SELW-1:0]   req_sel_i;
  logic [NREQ*LUT_IN-1:0] req_in_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ-1:0]        rsp_valid_o;
  logic                   rsp_data_o;

  // Client side: drives requests, sees grants and responses
  modport master (
    output req_valid_i, req_sel_i, req_in_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  // Evaluator side
  modport slave (
    input  req_valid_i, req_sel_i, req_in_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );

endinterface

// File: rtl/lut_eval_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer, wrapping; the pointer moves just past the winner.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] grant_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Pick a winner: first pass covers indices at/after the pointer, second pass wraps from 0
  always_comb begin
    logic found;
    logic hit;
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    hit     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      hit        = ~found & req_i[k] & (PW'(k) >= ptr_q);
      grant_o[k] = grant_o[k] | hit;
      ptr_d      = hit ? ((k == NREQ - 1) ? '0 : PW'(k + 1)) : ptr_d;
      found      = found | hit;
    end
    for (int k = 0; k < NREQ; k++) begin
      hit        = ~found & req_i[k];
      grant_o[k] = grant_o[k] | hit;
      ptr_d      = hit ? ((k == NREQ - 1) ? '0 : PW'(k + 1)) : ptr_d;
      found      = found | hit;
    end
  end

  // Pointer register; holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lut_eval_arbiter.sv
// Shared runtime-programmable 4-input LUT evaluator. NCFG truth tables are
// loaded bit-serially; NREQ clients are served one evaluation per cycle.
module lut_eval_arbiter
  import lut_eval_arbiter_pkg::*;
#(
  parameter  int NREQ = 3,
  parameter  int NCFG = 4,
  localparam int SELW = $clog2(NCFG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start_i,
  input  logic [SELW-1:0] cfg_slot_i,
  input  logic            cfg_bit_i,
  output logic            cfg_busy_o,
  output logic            cfg_done_o,
  lut_eval_arbiter_if.slave bus
);

  cfg_state_e        state_q, state_d;
  logic [SELW-1:0]   slot_q, slot_d;
  logic [LUT_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LUT_W-1:0]  tbl_q [NCFG];

  logic              busy_s;
  logic [NREQ-1:0]   elig_s;
  logic [NREQ-1:0]   grant_s;
  logic [SELW-1:0]   gsel_s;
  logic [LUT_IN-1:0] gin_s;

  logic [NREQ-1:0]   rsp_valid_q;
  logic              rsp_data_q;

  assign busy_s     = (state_q != IDLE);
  assign cfg_busy_o = busy_s;
  assign cfg_done_o = (state_q == COMMIT);

  // Load FSM next-state: latch slot on start, shift 16 bits LSB-first, commit for one cycle
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          state_d = LOAD;
          slot_d  = cfg_slot_i;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        sr_d  = {cfg_bit_i, sr_q[LUT_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = COMMIT;
        end else begin
          state_d = LOAD;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load FSM state, target slot, shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Truth-table storage; a slot changes only in the COMMIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCFG; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (state_q == COMMIT) begin
      tbl_q[slot_q] <= sr_q;
    end
  end

  // A requester is eligible unless it targets the slot currently being rewritten
  always_comb begin
    elig_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      elig_s[k] = bus.req_valid_i[k] &
                  ~(busy_s & (bus.req_sel_i[k*SELW +: SELW] == slot_q));
    end
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (elig_s),
    .grant_o (grant_s)
  );

  assign bus.req_ready_o = grant_s;

  // Steer the granted requester's slot index and inputs to the shared lookup
  always_comb begin
    gsel_s = '0;
    gin_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      gsel_s = gsel_s | ({SELW{grant_s[k]}}   & bus.req_sel_i[k*SELW +: SELW]);
      gin_s  = gin_s  | ({LUT_IN{grant_s[k]}} & bus.req_in_i[k*LUT_IN +: LUT_IN]);
    end
  end

  // Registered response: valid follows the grant by one cycle, data holds between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= 1'b0;
    end else begin
      rsp_valid_q <= grant_s;
      if (|grant_s) begin
        rsp_data_q <= lut_lookup(tbl_q[gsel_s], gin_s);
      end
    end
  end

  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;

endmodule
